// File: rtl/rx_frame_assembler_pkg.sv
// rtl/rx_frame_assembler_pkg.sv - shared frame state encodings and defaults
package rx_frame_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } frame_state_t;

  localparam logic [7:0] DEF_HEADER      = 8'hA5;
  localparam int         DEF_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/rx_frame_assembler_timeout_ctr.sv
// rtl/rx_frame_assembler_timeout_ctr.sv - inter-byte timeout counter
module frame_timeout_ctr
  import rx_frame_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] ctr_q, ctr_d;

  // A clear in the expiry cycle means a byte arrived in time, so it wins.
  assign expire_o = en_i && !clr_i && (ctr_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    ctr_d = ctr_q;
    if (clr_i) begin
      ctr_d = '0;
    end else if (en_i) begin
      ctr_d = ctr_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/rx_frame_assembler.sv
// rtl/rx_frame_assembler.sv - framed UART bytes to operand word with valid/ack
module rx_frame_assembler
  import rx_frame_assembler_pkg::*;
#(
  parameter int         NBYTES      = 4,
  parameter logic [7:0] HEADER      = DEF_HEADER,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                MCLK,
  input  logic                RST,
  input  logic [7:0]          DATAIN,
  input  logic                RX_Done,
  input  logic                WORD_ACK,
  output logic [8*NBYTES-1:0] WORD_OUT,
  output logic                WORD_VALID,
  output logic                CSUM_ERR,
  output logic                TIMEOUT_ERR,
  output logic                OVERRUN,
  output logic                BUSY
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);

  frame_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    acc_q, acc_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  word_q, word_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          csum_err_q, csum_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic          expire;

  frame_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i   (MCLK),
    .rst_ni  (RST),
    .clr_i   (RX_Done || (state_q == ST_IDLE)),
    .en_i    (state_q != ST_IDLE),
    .expire_o(expire)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    shift_d       = shift_q;
    word_d        = word_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;
    csum_err_d    = 1'b0;
    timeout_err_d = 1'b0;

    if (WORD_ACK && valid_q) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (RX_Done && (DATAIN == HEADER)) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        if (RX_Done) begin
          shift_d = (shift_q << 8) | W'(DATAIN);
          acc_d   = acc_q ^ DATAIN;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(NBYTES - 1)) begin
            state_d = ST_CHECK;
          end
        end else if (expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (RX_Done) begin
          state_d = ST_IDLE;
          if (DATAIN == acc_q) begin
            // An ack in the commit cycle frees the output slot for the new word.
            if (!valid_q || WORD_ACK) begin
              word_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            csum_err_d = 1'b1;
          end
        end else if (expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      shift_q       <= '0;
      word_q        <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      shift_q       <= shift_d;
      word_q        <= word_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      csum_err_q    <= csum_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign WORD_OUT    = word_q;
  assign WORD_VALID  = valid_q;
  assign CSUM_ERR    = csum_err_q;
  assign TIMEOUT_ERR = timeout_err_q;
  assign OVERRUN     = overrun_q;
  assign BUSY        = (state_q != ST_IDLE);

endmodule
